// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the pipelined Hack-style ALU.
// Optional feature macro: ALU_PIPE_CARRY_EN (adds carry/overflow flags).
package alu_pkg;

  // Default operand/result width.
  localparam int ALU_WIDTH_DEFAULT = 16;

  // Values of the functioncode control bit.
  localparam logic FN_AND = 1'b0;
  localparam logic FN_ADD = 1'b1;

  // The six Hack ALU control bits. The first field is the MSB, so a literal
  // such as 6'b000010 reads in the same order as the classic truth table.
  typedef struct packed {
    logic zerox;
    logic negx;
    logic zeroy;
    logic negy;
    logic functioncode;
    logic neg_out;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational output side of the ALU. It selects AND or ADD on
// the pre-processed operands, applies neg_out and derives the status flags
// from the final result.
// Optional feature macro: ALU_PIPE_CARRY_EN (adds out_carry / out_ovf).
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             functioncode,
  input  logic             neg_out,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_neg
`ifdef ALU_PIPE_CARRY_EN
  ,
  output logic             out_carry,
  output logic             out_ovf
`endif
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] r;

`ifdef ALU_PIPE_CARRY_EN
  // One extra bit on the adder keeps the carry-out at bit WIDTH.
  logic [WIDTH:0] sum_wide;

  assign sum_wide = {1'b0, a} + {1'b0, b};
  assign sum      = sum_wide[WIDTH-1:0];

  // Carry and overflow describe the raw sum, before neg_out, and only for ADD.
  always_comb begin
    out_carry = 1'b0;
    out_ovf   = 1'b0;
    if (functioncode == FN_ADD) begin
      out_carry = sum_wide[WIDTH];
      out_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
  end
`else
  // Plain modular add; the carry-out is simply dropped.
  assign sum = a + b;
`endif

  // Function select and output inversion.
  always_comb begin
    r = a & b;
    if (functioncode == FN_ADD) begin
      r = sum;
    end
    out = neg_out ? ~r : r;
  end

  // Status flags come from the final (possibly inverted) result.
  assign out_zero = (out == '0);
  assign out_neg  = out[WIDTH-1];

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined Hack-style ALU with valid/ready handshakes
// on both sides. S1 holds pre-processed operands, S2 holds the result and
// its status flags. At most two operations are in flight.
// Optional feature macro: ALU_PIPE_CARRY_EN (adds out_carry / out_ovf).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zerox,
  input  logic             negx,
  input  logic             zeroy,
  input  logic             negy,
  input  logic             functioncode,
  input  logic             neg_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_neg
`ifdef ALU_PIPE_CARRY_EN
  ,
  output logic             out_carry,
  output logic             out_ovf
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready is
  // high on that side. Payload and control are captured only on a transfer.
  // in_ready depends only on pipe state and out_ready, never on in_valid,
  // and out payload is held stable while out_valid && !out_ready.

  alu_ctrl_t        in_ctrl;
  logic [WIDTH-1:0] a_pre;
  logic [WIDTH-1:0] b_pre;

  // Stage 1 state.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_fn;
  logic             s1_neg_out;

  // Advance controls.
  logic             s2_take;
  logic             s1_take;

  // Combinational results of the output side, registered into S2.
  logic [WIDTH-1:0] core_out;
  logic             core_zero;
  logic             core_neg;
`ifdef ALU_PIPE_CARRY_EN
  logic             core_carry;
  logic             core_ovf;
`endif

  assign in_ctrl = '{
    zerox:        zerox,
    negx:         negx,
    zeroy:        zeroy,
    negy:         negy,
    functioncode: functioncode,
    neg_out:      neg_out
  };

  // Operand pre-processing: zeroing first, then inversion, so zero+invert
  // yields all ones.
  always_comb begin
    a_pre = in_ctrl.zerox ? '0 : x;
    if (in_ctrl.negx) begin
      a_pre = ~a_pre;
    end
    b_pre = in_ctrl.zeroy ? '0 : y;
    if (in_ctrl.negy) begin
      b_pre = ~b_pre;
    end
  end

  // A stage may load when it is empty or its occupant leaves this cycle.
  assign s2_take  = !out_valid || out_ready;
  assign s1_take  = !s1_valid || s2_take;
  assign in_ready = s1_take;

  // Stage 1 register: captures the pre-processed operands on input transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_fn      <= FN_AND;
      s1_neg_out <= 1'b0;
    end else if (s1_take) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a       <= a_pre;
        s1_b       <= b_pre;
        s1_fn      <= in_ctrl.functioncode;
        s1_neg_out <= in_ctrl.neg_out;
      end
    end
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a            (s1_a),
    .b            (s1_b),
    .functioncode (s1_fn),
    .neg_out      (s1_neg_out),
    .out          (core_out),
    .out_zero     (core_zero),
    .out_neg      (core_neg)
`ifdef ALU_PIPE_CARRY_EN
    ,
    .out_carry    (core_carry),
    .out_ovf      (core_ovf)
`endif
  );

  // Stage 2 register: takes the S1 result whenever S2 is free to advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
    end else if (s2_take) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out      <= core_out;
        out_zero <= core_zero;
        out_neg  <= core_neg;
      end
    end
  end

`ifdef ALU_PIPE_CARRY_EN
  // Carry/overflow flags travel with the S2 result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (s2_take && s1_valid) begin
      out_carry <= core_carry;
      out_ovf   <= core_ovf;
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH=16), with a WIDTH=8
// carry/overflow sequence when ALU_PIPE_CARRY_EN is defined.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W  = 16;
  localparam int EW = W + 2;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    alu_ctrl_t    c;
    logic [W-1:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  alu_ctrl_t    ctrl = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out;
  logic         out_zero;
  logic         out_neg;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic          held_v = 1'b0;
  logic [EW-1:0] held_val = '0;
  logic          stream_done = 1'b0;
  vec_t          tbl[14];

`ifdef ALU_PIPE_CARRY_EN
  logic       c16, v16;
  logic [7:0] x8 = '0, y8 = '0, o8;
  alu_ctrl_t  c8 = '0;
  logic       iv8 = 1'b0, or8 = 1'b1, ir8, ov8, z8, n8, cy8, of8;
`endif

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .zerox(ctrl.zerox), .negx(ctrl.negx), .zeroy(ctrl.zeroy),
    .negy(ctrl.negy), .functioncode(ctrl.functioncode), .neg_out(ctrl.neg_out),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_zero(out_zero), .out_neg(out_neg)
`ifdef ALU_PIPE_CARRY_EN
    , .out_carry(c16), .out_ovf(v16)
`endif
  );

`ifdef ALU_PIPE_CARRY_EN
  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .x(x8), .y(y8), .zerox(c8.zerox), .negx(c8.negx), .zeroy(c8.zeroy),
    .negy(c8.negy), .functioncode(c8.functioncode), .neg_out(c8.neg_out),
    .out_valid(ov8), .out_ready(or8), .out(o8),
    .out_zero(z8), .out_neg(n8), .out_carry(cy8), .out_ovf(of8)
  );
`endif

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_exp(input logic [W-1:0] r);
    return {r, (r == '0), r[W-1]};
  endfunction

  // Reference behaviour of one operation, written from the Hack ALU rules.
  function automatic logic [EW-1:0] model(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                          input alu_ctrl_t c);
    logic [W-1:0] a, b, r;
    a = c.zerox ? '0 : xv;
    if (c.negx) a = ~a;
    b = c.zeroy ? '0 : yv;
    if (c.negy) b = ~b;
    r = c.functioncode ? (a + b) : (a & b);
    if (c.neg_out) r = ~r;
    return pack_exp(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: present one op, wait for acceptance, queue its expected result.
  task automatic send(input logic [W-1:0] xv, input logic [W-1:0] yv,
                      input alu_ctrl_t c, input logic [EW-1:0] e);
    int n;
    logic ok;
    n = 0;
    ok = 1'b0;
    x = xv;
    y = yv;
    ctrl = c;
    in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    if (ok) begin
      exp_q.push_back(e);
    end else begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got no acceptance expected acceptance within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Let every queued result emerge with out_ready high.
  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: compare each output transfer and check held payload stability.
  always @(negedge clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    act = {out, out_zero, out_neg};
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) chk("held_payload", 32'(act), 32'(held_val));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got 0x%0h expected no output", act);
        end else begin
          e = exp_q.pop_front();
          chk("result", 32'(act), 32'(e));
        end
      end
      held_v = out_valid && !out_ready;
      held_val = act;
    end
  end

  initial begin
    tbl[0]  = '{16'd5,      16'd3,      alu_ctrl_t'(6'b101010), 16'h0000};
    tbl[1]  = '{16'd5,      16'd3,      alu_ctrl_t'(6'b111111), 16'h0001};
    tbl[2]  = '{16'd5,      16'd3,      alu_ctrl_t'(6'b111010), 16'hFFFF};
    tbl[3]  = '{16'd5,      16'd3,      alu_ctrl_t'(6'b001100), 16'h0005};
    tbl[4]  = '{16'd5,      16'd3,      alu_ctrl_t'(6'b110000), 16'h0003};
    tbl[5]  = '{16'd5,      16'd3,      alu_ctrl_t'(6'b001101), 16'hFFFA};
    tbl[6]  = '{16'd5,      16'd3,      alu_ctrl_t'(6'b000010), 16'h0008};
    tbl[7]  = '{16'd5,      16'd3,      alu_ctrl_t'(6'b010011), 16'h0002};
    tbl[8]  = '{16'd5,      16'd3,      alu_ctrl_t'(6'b000111), 16'hFFFE};
    tbl[9]  = '{16'd5,      16'd3,      alu_ctrl_t'(6'b000000), 16'h0001};
    tbl[10] = '{16'd5,      16'd3,      alu_ctrl_t'(6'b010101), 16'h0007};
    tbl[11] = '{16'd5,      16'd3,      alu_ctrl_t'(6'b111011), 16'h0000};
    tbl[12] = '{16'h8000,   16'h8000,   alu_ctrl_t'(6'b000010), 16'h0000};
    tbl[13] = '{16'h00F0,   16'h0FF0,   alu_ctrl_t'(6'b000000), 16'h00F0};

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_flags", 32'({out_zero, out_neg}), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Single ADD: 2-cycle latency, then out_valid drops.
    out_ready = 1'b1;
    send(16'd5, 16'd3, alu_ctrl_t'(6'b000010), pack_exp(16'h0008));
    @(negedge clk);
    chk("latency_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_cycle2_valid", 32'(out_valid), 32'd1);
    chk("latency_out", 32'(out), 32'h0008);
    @(negedge clk);
    chk("latency_after_valid", 32'(out_valid), 32'd0);
    tick();

    // Back-to-back issue: x-1 with x=0, then zero+zero.
    send(16'h0000, 16'h1234, alu_ctrl_t'(6'b001110), pack_exp(16'hFFFF));
    send(16'h4321, 16'h1234, alu_ctrl_t'(6'b101010), pack_exp(16'h0000));
    @(negedge clk);
    chk("b2b_first_valid", 32'(out_valid), 32'd1);
    chk("b2b_first_out", 32'({out, out_neg}), 32'({16'hFFFF, 1'b1}));
    @(negedge clk);
    chk("b2b_second_valid", 32'(out_valid), 32'd1);
    chk("b2b_second_zero", 32'(out_zero), 32'd1);
    @(negedge clk);
    chk("b2b_after_valid", 32'(out_valid), 32'd0);
    tick();

    // Table of function codes, streamed back to back.
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].x, tbl[i].y, tbl[i].c, pack_exp(tbl[i].exp));
    end
    drain();

    // Backpressure: A and B fill the pipe, C waits.
    out_ready = 1'b0;
    send(16'd5, 16'd3, alu_ctrl_t'(6'b000010), pack_exp(16'h0008));
    send(16'd5, 16'd3, alu_ctrl_t'(6'b000000), pack_exp(16'h0001));
    x = 16'd5;
    y = 16'd3;
    ctrl = alu_ctrl_t'(6'b101011);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out", 32'({out_valid, out}), 32'({1'b1, 16'h0008}));
    end
    tick();
    out_ready = 1'b1;
    send(16'd5, 16'd3, alu_ctrl_t'(6'b101011), pack_exp(16'hFFFF));
    drain();

    // Random stream with out_ready toggling every cycle.
    out_ready = 1'b0;
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [W-1:0] xr, yr;
          alu_ctrl_t cr;
          xr = W'($urandom_range(0, 16'hFFFF));
          yr = W'($urandom_range(0, 16'hFFFF));
          cr = alu_ctrl_t'($urandom_range(0, 63));
          send(xr, yr, cr, model(xr, yr, cr));
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          out_ready = ~out_ready;
          tick();
        end
      end
    join
    drain();

    // Reset with a full pipe discards both in-flight ops.
    out_ready = 1'b0;
    send(16'd1, 16'd2, alu_ctrl_t'(6'b000010), pack_exp(16'h0003));
    send(16'd1, 16'd2, alu_ctrl_t'(6'b000000), pack_exp(16'h0000));
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_out", 32'({out, out_zero, out_neg}), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    tick();
    out_ready = 1'b1;
    send(16'd7, 16'd9, alu_ctrl_t'(6'b000010), pack_exp(16'h0010));
    drain();

`ifdef ALU_PIPE_CARRY_EN
    // WIDTH=8 carry and signed overflow.
    c8 = alu_ctrl_t'(6'b000010);
    x8 = 8'hFF;
    y8 = 8'h01;
    iv8 = 1'b1;
    tick();
    x8 = 8'h7F;
    tick();
    iv8 = 1'b0;
    @(negedge clk);
    chk("w8_carry_case", 32'({ov8, o8, z8, n8, cy8, of8}), 32'({1'b1, 8'h00, 4'b1010}));
    tick();
    @(negedge clk);
    chk("w8_ovf_case", 32'({ov8, o8, z8, n8, cy8, of8}), 32'({1'b1, 8'h80, 4'b0101}));
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
